// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: ALU op selects, LC-3b operate opcodes, sequencer state encoding and decode helpers
package alu_seq_pkg;
  typedef enum logic [1:0] {
    ALUK_ADD   = 2'd0,
    ALUK_AND   = 2'd1,
    ALUK_XOR   = 2'd2,
    ALUK_PASSA = 2'd3
  } aluk_t;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b1001;
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  function automatic logic op_legal(input logic [3:0] op);
    return op == OP_ADD || op == OP_AND || op == OP_XOR;
  endfunction
  function automatic aluk_t op_aluk(input logic [3:0] op);
    return op == OP_AND ? ALUK_AND : op == OP_XOR ? ALUK_XOR : ALUK_ADD;
  endfunction
endpackage

// File: rtl/alu_seq_sext5.sv
// sext5: sign-extends a 5-bit immediate to 16 bits (a: imm5 in, y: 16-bit result)
module sext5 (
  input  logic [4:0]  a,
  output logic [15:0] y
);
  assign y = {{11{a[4]}}, a};
endmodule

// File: rtl/alu_seq.sv
// alu_seq: LC-3b operate-instruction sequencer (clk/rst/start/ir in; datapath controls, status, op_count out)
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      ir,
  output logic [1:0]       aluk,
  output logic [2:0]       sr1,
  output logic [2:0]       sr2,
  output logic             sr2mux,
  output logic [15:0]      imm,
  output logic             gate_alu,
  output logic             ld_reg,
  output logic             ld_cc,
  output logic [2:0]       dr,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count
);
  state_t state, next;
  logic [15:0] ir_q, sext;
  logic ill_q, act;
  sext5 u_sext (.a(ir_q[4:0]), .y(sext));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ir_q     <= '0;
      ill_q    <= 1'b0;
      op_count <= '0;
    end else begin
      if (state == IDLE && start) ir_q <= ir;
      ill_q <= state == DECODE && !op_legal(ir_q[15:12]);
      if (state == WB) op_count <= op_count + CNT_W'(1);
    end
  always_comb
    next = state == IDLE   ? (start ? DECODE : IDLE) :
           state == DECODE ? (op_legal(ir_q[15:12]) ? EXEC : IDLE) :
           state == EXEC   ? WB : IDLE;
  // outputs depend on state only, so an async reset clears them at once
  always_comb begin
    act      = state != IDLE;
    aluk     = act ? op_aluk(ir_q[15:12]) : ALUK_PASSA;
    sr1      = act ? ir_q[8:6] : '0;
    sr2      = act ? ir_q[2:0] : '0;
    dr       = act ? ir_q[11:9] : '0;
    sr2mux   = act & ir_q[5];
    imm      = act ? sext : '0;
    gate_alu = state == EXEC || state == WB;
    ld_reg   = state == WB;
    ld_cc    = state == WB;
    done     = state == WB;
    busy     = act;
    illegal  = ill_q;
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with directed operate instructions
module tb_alu_seq;
  logic clk, rst, start;
  logic [15:0] ir, imm;
  logic [1:0] aluk, op_count;
  logic [2:0] sr1, sr2, dr;
  logic sr2mux, gate_alu, ld_reg, ld_cc, busy, done, illegal;
  typedef struct {
    logic [15:0] ir;
    bit          ill;
    logic [1:0]  aluk;
    logic [2:0]  sr1, sr2, dr;
    bit          mux;
    logic [15:0] imm;
    logic [1:0]  cnt;
  } exp_t;
  exp_t q[$];
  exp_t tbl[9];
  int cmp = 0, err = 0;
  alu_seq #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .ir(ir), .aluk(aluk), .sr1(sr1), .sr2(sr2),
    .sr2mux(sr2mux), .imm(imm), .gate_alu(gate_alu), .ld_reg(ld_reg), .ld_cc(ld_cc),
    .dr(dr), .busy(busy), .done(done), .illegal(illegal), .op_count(op_count)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic issue(input exp_t e, input bit hold);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 20);
    if (busy) chk("issue_timeout", 1, 0);
    ir = e.ir;
    start = 1;
    q.push_back(e);
    @(negedge clk);
    if (!hold) start = 0;
    ir = 16'hFFFF;
  endtask
  initial begin
    int run = 0;
    bit pend = 0;
    logic [1:0] pv = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("op_count_after", op_count, pv);
        pend = 0;
      end
      if (busy) run++;
      if (busy && q.size() > 0 && !q[0].ill) begin
        chk("aluk", aluk, q[0].aluk);
        chk("sr1", sr1, q[0].sr1);
        chk("sr2", sr2, q[0].sr2);
        chk("dr", dr, q[0].dr);
        chk("sr2mux", sr2mux, q[0].mux);
        chk("imm", imm, q[0].imm);
      end
      if (!busy) begin
        chk("idle_ctl", {gate_alu, ld_reg, ld_cc, sr2mux, done}, 0);
        chk("idle_aluk", aluk, 3);
      end else begin
        chk("gate", gate_alu, run >= 2);
        if (!done) chk("no_ld", {ld_reg, ld_cc}, 0);
      end
      if (done || illegal) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("kind", illegal, e.ill);
          chk("done", done, !e.ill);
          chk("latency", run, e.ill ? 1 : 3);
          if (done) chk("wb_ctl", {gate_alu, ld_reg, ld_cc}, 3'b111);
          if (illegal) chk("ill_cnt", op_count, e.cnt);
          else begin
            pend = 1;
            pv = e.cnt;
          end
        end
      end
      if (!busy) run = 0;
    end
  end
  initial begin
    int t;
    tbl[0] = '{16'h1283, 0, 2'd0, 3'd2, 3'd3, 3'd1, 0, 16'h0003, 2'd1};
    tbl[1] = '{16'h5030, 0, 2'd1, 3'd0, 3'd0, 3'd0, 1, 16'hFFF0, 2'd2};
    tbl[2] = '{16'h997F, 0, 2'd2, 3'd5, 3'd7, 3'd4, 1, 16'hFFFF, 2'd3};
    tbl[3] = '{16'h0000, 1, 2'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 2'd3};
    tbl[4] = '{16'hD000, 1, 2'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 2'd3};
    tbl[5] = '{16'h1283, 0, 2'd0, 3'd2, 3'd3, 3'd1, 0, 16'h0003, 2'd0};
    tbl[6] = '{16'h5030, 0, 2'd1, 3'd0, 3'd0, 3'd0, 1, 16'hFFF0, 2'd1};
    tbl[7] = '{16'h997F, 0, 2'd2, 3'd5, 3'd7, 3'd4, 1, 16'hFFFF, 2'd2};
    tbl[8] = '{16'h1A42, 0, 2'd0, 3'd1, 3'd2, 3'd5, 0, 16'h0002, 2'd3};
    rst = 1;
    start = 0;
    ir = 0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {busy, done, illegal, gate_alu, ld_reg, ld_cc, sr2mux}, 0);
    chk("rst_aluk", aluk, 3);
    chk("rst_fields", {sr1, sr2, dr, imm}, 0);
    chk("rst_cnt", op_count, 0);
    rst = 0;
    issue(tbl[0], 0);
    @(negedge clk);
    chk("exec_gate", gate_alu, 1);
    #2 rst = 1;
    #1;
    chk("abort_gate_busy", {gate_alu, busy}, 0);
    chk("abort_ld", {ld_reg, ld_cc, done}, 0);
    chk("abort_aluk", aluk, 3);
    chk("abort_fields", {sr1, sr2, dr, imm, sr2mux}, 0);
    chk("abort_cnt", op_count, 0);
    q.delete();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) issue(tbl[i], 0);
    for (int i = 5; i < 9; i++) issue(tbl[i], 1);
    t = 0;
    while ((q.size() != 0 || busy) && t < 40) begin
      @(negedge clk);
      start = 0;
      t++;
    end
    chk("drain", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-002 The block SHALL have port clk, input, 1 bit, single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset; asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, request to execute the operate instruction on ir.
REQ-005 The block SHALL have port ir, input, 16 bits, LC-3b instruction word; sampled only on an accepted start.
REQ-006 The block SHALL have port aluk, output, 2 bits, ALU operation select (ALUK_ADD/AND/XOR/PASSA).
REQ-007 The block SHALL have ports sr1 and sr2, output, 3 bits each, register-file read addresses.
REQ-008 The block SHALL have port sr2mux, output, 1 bit, 1 = ALU B from imm, 0 = from register sr2.
REQ-009 The block SHALL have port imm, output, 16 bits, sign-extended imm5.
REQ-010 The block SHALL have ports gate_alu, ld_reg, ld_cc, output, 1 bit each, bus gate, register write enable, condition-code load.
REQ-011 The block SHALL have port dr, output, 3 bits, destination register address.
REQ-012 The block SHALL have ports busy, done and illegal, output, 1 bit each, status; done and illegal are one-cycle pulses.
REQ-013 The block SHALL have port op_count, output, CNT_W bits, number of completed operations.

Function
REQ-014 The FSM SHALL have states IDLE, DECODE, EXEC and WB.
- IDLE -> DECODE on start.
- DECODE -> EXEC for a legal opcode; DECODE -> IDLE otherwise.
- EXEC -> WB.
- WB -> IDLE.
REQ-015 Start SHALL be accepted only in IDLE; ir is latched on that edge; start in any other state is ignored and not queued.
REQ-016 Legal opcodes (ir[15:12]) SHALL be exactly ADD=0001, AND=0101, XOR=1001; any other opcode is illegal.
REQ-017 DECODE SHALL drive the datapath fields from the latched ir.
- Register fields: dr=ir[11:9], sr1=ir[8:6], sr2=ir[2:0].
- Source select: sr2mux=ir[5].
- Immediate: imm={{11{ir[4]}},ir[4:0]}.
- ALU op: aluk from the opcode.
REQ-018 These fields SHALL remain stable through EXEC and WB.
REQ-019 EXEC SHALL assert gate_alu=1 with ld_reg=0 and ld_cc=0.
REQ-020 WB SHALL assert gate_alu=1, ld_reg=1 and ld_cc=1 for exactly one cycle; done pulses in the same cycle.
REQ-021 Latency for a legal op: start sampled at edge k; WB (and done) SHALL be the cycle after edge k+2; busy SHALL be high from edge k to edge k+3.
REQ-022 An illegal opcode SHALL pulse illegal in the cycle after DECODE, then return to IDLE.
- No gate_alu, ld_reg or ld_cc is asserted.
- op_count is unchanged.
REQ-023 op_count SHALL increment by 1 on each WB and wrap from all-ones to 0.
REQ-024 When not in DECODE/EXEC/WB, aluk SHALL be ALUK_PASSA and gate_alu, ld_reg, ld_cc and sr2mux SHALL be 0.
REQ-025 start held high continuously SHALL begin a new operation on the first edge back in IDLE (one idle cycle between ops).

Reset
REQ-026 When rst is asserted at any time, including mid-operation, the block SHALL immediately:
- enter IDLE;
- force the control outputs gate_alu, ld_reg, ld_cc, busy, done and illegal to 0;
- force aluk to ALUK_PASSA and sr1, sr2, dr, imm and sr2mux to 0;
- force op_count to 0.
REQ-027 No partial write (ld_reg) SHALL occur after an aborted operation.

Structure
REQ-028 The ALUK_* and opcode constants and the state encoding SHALL live in the shared ALU header alongside the existing ALUK definitions.
REQ-029 The block SHALL contain one sub-module, sext5 (5-to-16-bit sign extender); the FSM, decode and counter SHALL be inline.

Verification
REQ-030 ir=0x1283 (ADD R1,R2,R3) with start -> after DECODE: aluk=ADD, sr1=2, sr2=3, sr2mux=0, dr=1; WB plus done 3 cycles after start; op_count=1.
REQ-031 ir=0x5030 (AND R0,R0,#-16) -> imm=0xFFF0, sr2mux=1, aluk=AND, dr=0.
REQ-032 ir=0x997F (NOT R4,R5 as XOR #-1) -> aluk=XOR, imm=0xFFFF, sr1=5, dr=4.
REQ-033 ir=0x0000 -> illegal pulse, no gate_alu or ld_reg, op_count unchanged.
REQ-034 rst pulsed during EXEC of 0x1283 -> gate_alu and busy drop immediately, no ld_reg, op_count=0; a new start then completes normally.
REQ-035 Counter wrap: CNT_W=2, 4 back-to-back ops -> op_count sequence 1,2,3,0; start pulses during busy are ignored.
